// File: rtl/vscale_wb_queue.sv
// Register-file write-port manager: in-order load destination queue, response capture,
// write-port merge with writeback priority, scoreboard busy flags and forced starvation drain.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef XPR_LEN
`define XPR_LEN 32
`endif

module vscale_wb_queue #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alloc_valid,
  input  logic [`REG_ADDR_WIDTH-1:0] alloc_wa,
  output logic                       alloc_ready,
  input  logic                       resp_valid,
  input  logic [`XPR_LEN-1:0]        resp_data,
  input  logic                       pipe_wen,
  input  logic [`REG_ADDR_WIDTH-1:0] pipe_wa,
  input  logic [`XPR_LEN-1:0]        pipe_wd,
  output logic                       rf_wen,
  output logic [`REG_ADDR_WIDTH-1:0] rf_wa,
  output logic [`XPR_LEN-1:0]        rf_wd,
  input  logic [`REG_ADDR_WIDTH-1:0] chk_ra1,
  input  logic [`REG_ADDR_WIDTH-1:0] chk_ra2,
  input  logic [`REG_ADDR_WIDTH-1:0] chk_wa,
  output logic                       busy1,
  output logic                       busy2,
  output logic                       busy_w,
  output logic                       pipe_stall,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       resp_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0]           ent_valid;
  logic [DEPTH-1:0]           ent_filled;
  logic [`REG_ADDR_WIDTH-1:0] ent_wa   [DEPTH];
  logic [`XPR_LEN-1:0]        ent_data [DEPTH];

  logic [PW-1:0] alloc_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] drain_ptr;
  logic [7:0]    starve_cnt;

  logic do_alloc;
  logic do_fill;
  logic do_pop;
  logic head_rdy;
  logic pipe_sel;

  assign alloc_ready = (count < CW'(DEPTH));
  assign do_alloc    = alloc_valid && alloc_ready;
  // Responses only ever land on an entry that already existed before this edge.
  assign do_fill     = resp_valid && ent_valid[fill_ptr] && !ent_filled[fill_ptr];
  assign head_rdy    = ent_valid[drain_ptr] && ent_filled[drain_ptr];
  assign pipe_stall  = (starve_cnt == 8'(STARVE_LIMIT));
  assign pipe_sel    = pipe_wen && !pipe_stall;
  assign do_pop      = head_rdy && !pipe_sel;

  always_comb begin
    rf_wen = 1'b0;
    rf_wa  = pipe_wa;
    rf_wd  = pipe_wd;
    if (pipe_sel) begin
      rf_wen = 1'b1;
    end else if (head_rdy) begin
      rf_wen = (ent_wa[drain_ptr] != '0);
      rf_wa  = ent_wa[drain_ptr];
      rf_wd  = ent_data[drain_ptr];
    end
    if (reset) rf_wen = 1'b0;
  end

  always_comb begin
    busy1  = 1'b0;
    busy2  = 1'b0;
    busy_w = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) begin
        if (ent_wa[i] == chk_ra1) busy1  = 1'b1;
        if (ent_wa[i] == chk_ra2) busy2  = 1'b1;
        if (ent_wa[i] == chk_wa)  busy_w = 1'b1;
      end
    end
    if (chk_ra1 == '0) busy1  = 1'b0;
    if (chk_ra2 == '0) busy2  = 1'b0;
    if (chk_wa  == '0) busy_w = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_valid  <= '0;
      ent_filled <= '0;
      alloc_ptr  <= '0;
      fill_ptr   <= '0;
      drain_ptr  <= '0;
      count      <= '0;
      starve_cnt <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (do_alloc) begin
        ent_valid[alloc_ptr]  <= 1'b1;
        ent_filled[alloc_ptr] <= 1'b0;
        alloc_ptr             <= alloc_ptr + 1'b1;
      end
      if (do_fill) begin
        ent_filled[fill_ptr] <= 1'b1;
        fill_ptr             <= fill_ptr + 1'b1;
      end else if (resp_valid) begin
        resp_err <= 1'b1;
      end
      if (do_pop) begin
        ent_valid[drain_ptr]  <= 1'b0;
        ent_filled[drain_ptr] <= 1'b0;
        drain_ptr             <= drain_ptr + 1'b1;
      end
      case ({do_alloc, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A stalled cycle always pops, so the counter never runs past the limit.
      if (do_pop || !head_rdy)
        starve_cnt <= '0;
      else if (pipe_sel)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_alloc) ent_wa[alloc_ptr]  <= alloc_wa;
    if (do_fill)  ent_data[fill_ptr] <= resp_data;
  end

endmodule
